// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: word/byte loads and stores after WAIT_CYCLES wait states, stalling the pipeline meanwhile.
// Optional posted-write buffer enabled by defining DMEM_POSTED_WRITE_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        byteMode,
  input  logic [15:0] address,
  input  logic [15:0] dataWrite,
  output logic [15:0] dataRead,
  output logic        stall,
  output logic        ready,
  output logic        alignErr
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            wr_q, byte_q, hi_q;
  logic [AW-1:0]   idx_q;
  logic [15:0]     wdat_q, dread_q;
  logic            ready_q, aerr_q;
  logic [15:0]     mem_q [DEPTH_WORDS];

  logic            req, mis_in, mis_q, accept;
  logic [AW-1:0]   req_idx;
  logic [15:0]     word_rd, rd_val;
  logic            unused_addr;

  assign req         = memRead | memWrite;
  assign mis_in      = ~byteMode & address[0];
  assign req_idx     = address[AW:1];
  assign mis_q       = ~byte_q & hi_q;
  assign unused_addr = ^address[15:AW+1];
  assign dataRead    = dread_q;

`ifdef DMEM_POSTED_WRITE_EN
  logic            pb_vld_q;
  logic [AW-1:0]   pb_idx_q;
  logic [1:0]      pb_be_q;
  logic [15:0]     pb_dat_q;
  logic [3:0]      pb_cnt_q;
  logic            post_go;
  logic            unused_wdat;

  assign unused_wdat = ^wdat_q;
  assign post_go  = (state_q == S_IDLE) & memWrite & ~pb_vld_q;
  // Reads to another word wait for the buffer to drain so RAM order is preserved.
  assign accept   = (state_q == S_IDLE) & memRead & ~memWrite &
                    (~pb_vld_q | (req_idx == pb_idx_q));
  assign stall    = ((state_q == S_IDLE) & req & ~post_go) | (state_q == S_WAIT);
  assign ready    = ready_q | post_go;
  assign alignErr = aerr_q | (post_go & mis_in);

  always_comb begin
    word_rd = mem_q[idx_q];
    if (pb_vld_q && (pb_idx_q == idx_q)) begin
      if (pb_be_q[0]) word_rd[7:0]  = pb_dat_q[7:0];
      if (pb_be_q[1]) word_rd[15:8] = pb_dat_q[15:8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pb_vld_q <= 1'b0;
      pb_idx_q <= '0;
      pb_be_q  <= 2'b00;
      pb_dat_q <= 16'h0000;
      pb_cnt_q <= 4'd0;
    end else if (post_go && !mis_in) begin
      pb_vld_q <= 1'b1;
      pb_idx_q <= req_idx;
      pb_cnt_q <= 4'(WAIT_CYCLES);
      if (!byteMode) begin
        pb_be_q  <= 2'b11;
        pb_dat_q <= dataWrite;
      end else if (address[0]) begin
        pb_be_q  <= 2'b10;
        pb_dat_q <= {dataWrite[7:0], 8'h00};
      end else begin
        pb_be_q  <= 2'b01;
        pb_dat_q <= {8'h00, dataWrite[7:0]};
      end
    end else if (pb_vld_q) begin
      if (pb_cnt_q == 4'd0) pb_vld_q <= 1'b0;
      else                  pb_cnt_q <= pb_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (pb_vld_q && (pb_cnt_q == 4'd0)) begin
      if (pb_be_q[0]) mem_q[pb_idx_q][7:0]  <= pb_dat_q[7:0];
      if (pb_be_q[1]) mem_q[pb_idx_q][15:8] <= pb_dat_q[15:8];
    end
  end
`else
  assign accept   = (state_q == S_IDLE) & req;
  assign stall    = ((state_q == S_IDLE) & req) | (state_q == S_WAIT);
  assign ready    = ready_q;
  assign alignErr = aerr_q;
  assign word_rd  = mem_q[idx_q];

  always_ff @(posedge clk) begin
    if ((state_q == S_RESP) && wr_q && !mis_q) begin
      if (!byte_q)   mem_q[idx_q]        <= wdat_q;
      else if (hi_q) mem_q[idx_q][15:8]  <= wdat_q[7:0];
      else           mem_q[idx_q][7:0]   <= wdat_q[7:0];
    end
  end
`endif

  assign rd_val = mis_q  ? 16'h0000 :
                  !byte_q ? word_rd :
                  hi_q   ? {8'h00, word_rd[15:8]} : {8'h00, word_rd[7:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      hi_q    <= 1'b0;
      idx_q   <= '0;
      wdat_q  <= 16'h0000;
      dread_q <= 16'h0000;
      ready_q <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      aerr_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          wr_q   <= memWrite;
          byte_q <= byteMode;
          hi_q   <= address[0];
          idx_q  <= req_idx;
          wdat_q <= dataWrite;
          cnt_q  <= 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            aerr_q  <= mis_in;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            aerr_q  <= mis_q;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          if (!wr_q) dread_q <= rd_val;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, reset-abort sequence, randomized traffic vs. a word-array model.
module tb_dmem_responder;
  localparam int W = 2;
`ifdef DMEM_POSTED_WRITE_EN
  localparam int WR_STALL = 0;
`else
  localparam int WR_STALL = W + 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        memRead = 1'b0, memWrite = 1'b0, byteMode = 1'b0;
  logic [15:0] address = 16'h0000, dataWrite = 16'h0000;
  logic [15:0] dataRead;
  logic        stall, ready, alignErr;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset_n(reset_n), .memRead(memRead), .memWrite(memWrite),
    .byteMode(byteMode), .address(address), .dataWrite(dataWrite),
    .dataRead(dataRead), .stall(stall), .ready(ready), .alignErr(alignErr)
  );

  int total = 0;
  int bad = 0;

  logic [15:0] ref_mem [256];
  logic [15:0] ref_dread = 16'h0000;

  typedef struct {
    logic rd, wr, bm;
    logic [15:0] a, wd, edr;
    logic eae;
  } vec_t;
  vec_t tbl [17];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: byte-addressed little-endian memory of 16-bit words, word index = a[8:1].
  task automatic ref_op(input logic rd, wr, bm, input logic [15:0] a, wd,
                        output logic eae, output logic [15:0] edr);
    int idx, lane;
    logic [15:0] m;
    idx  = int'(a[8:1]);
    lane = int'(a[0]);
    eae  = !bm && a[0];
    m    = ref_mem[idx];
    if (wr) begin
      if (!eae) begin
        if (bm) m = (m & ~(16'h00FF << (8 * lane))) | ({8'h00, wd[7:0]} << (8 * lane));
        else    m = wd;
        ref_mem[idx] = m;
      end
    end else if (rd) begin
      if (eae)     ref_dread = 16'h0000;
      else if (bm) ref_dread = (m >> (8 * lane)) & 16'h00FF;
      else         ref_dread = m;
    end
    edr = ref_dread;
  endtask

  task automatic access(input logic rd, wr, bm, input logic [15:0] a, wd,
                        output int scnt, output logic ae, output logic [15:0] dr);
    int cyc;
    logic seen;
    memRead = rd; memWrite = wr; byteMode = bm; address = a; dataWrite = wd;
    scnt = 0; seen = 1'b0; ae = 1'b0; cyc = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      if (stall) scnt++;
      if (ready) begin
        seen = 1'b1;
        ae = alignErr;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got no ready within %0d cycles, expected one", cyc);
    end
    memRead = 1'b0; memWrite = 1'b0;
    #1;
    check("ready_one_cycle", 32'(ready), 32'd0);
    dr = dataRead;
  endtask

  task automatic run(input string nm, input logic rd, wr, bm, input logic [15:0] a, wd,
                     input logic [15:0] edr, input logic eae, input int estall);
    int sc;
    logic ae;
    logic [15:0] dr;
    access(rd, wr, bm, a, wd, sc, ae, dr);
    if (estall < 0) begin
      total++;
      if (sc < W + 1) begin
        bad++;
        $display("FAIL %s_stall: got %0d expected at least %0d", nm, sc, W + 1);
      end
    end else begin
      check({nm, "_stall"}, 32'(sc), 32'(estall));
    end
    check({nm, "_aerr"}, 32'(ae), 32'(eae));
    check({nm, "_data"}, 32'(dr), 32'(edr));
  endtask

  initial begin
    logic mae;
    logic [15:0] mdr, a;
    int est;
    logic rd, wr, bm;

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 16'h0011, 16'h005A, 16'hBEEF, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h5AEF, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 16'h0011, 16'h0000, 16'h005A, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h00EF, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h0012, 16'h1111, 16'h00EF, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0013, 16'h0000, 16'h0000, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'h0013, 16'hFFFF, 16'h0000, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h0012, 16'h0000, 16'h1111, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 16'h0020, 16'h1234, 16'h1111, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 16'h0020, 16'h77AB, 16'h1234, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 16'h0021, 16'h0000, 16'h0012, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 16'h8020, 16'h0000, 16'h12AB, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 16'h0030, 16'h5555, 16'h12AB, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h5AEF, 1'b0};

    #12;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_aerr", 32'(alignErr), 32'd0);
    check("rst_data", 32'(dataRead), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      ref_op(tbl[i].rd, tbl[i].wr, tbl[i].bm, tbl[i].a, tbl[i].wd, mae, mdr);
      run($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].bm, tbl[i].a, tbl[i].wd,
          tbl[i].edr, tbl[i].eae, tbl[i].wr ? WR_STALL : W + 1);
    end

    // Reset during a store: outputs clear at once and the old word survives.
    memWrite = 1'b1; byteMode = 1'b0; address = 16'h0030; dataWrite = 16'hAAAA;
    @(posedge clk); #1;
`ifndef DMEM_POSTED_WRITE_EN
    check("wait_stall", 32'(stall), 32'd1);
`endif
    #2;
    reset_n = 1'b0; memWrite = 1'b0;
    #1;
    ref_dread = 16'h0000;
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_aerr", 32'(alignErr), 32'd0);
    check("abort_data", 32'(dataRead), 32'd0);
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    ref_op(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, mae, mdr);
    run("after_abort", 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, 16'h5555, 1'b0, W + 1);

`ifdef DMEM_POSTED_WRITE_EN
    ref_op(1'b0, 1'b1, 1'b0, 16'h0042, 16'h7777, mae, mdr);
    run("p_st42", 1'b0, 1'b1, 1'b0, 16'h0042, 16'h7777, mdr, 1'b0, 0);
    repeat (6) @(posedge clk);
    #1;
    ref_op(1'b0, 1'b1, 1'b0, 16'h0040, 16'hCAFE, mae, mdr);
    run("p_st40", 1'b0, 1'b1, 1'b0, 16'h0040, 16'hCAFE, mdr, 1'b0, 0);
    ref_op(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, mae, mdr);
    run("p_ld40", 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'hCAFE, 1'b0, W + 1);
    ref_op(1'b0, 1'b1, 1'b0, 16'h0040, 16'hBEAD, mae, mdr);
    run("p_st40b", 1'b0, 1'b1, 1'b0, 16'h0040, 16'hBEAD, mdr, 1'b0, 0);
    ref_op(1'b1, 1'b0, 1'b0, 16'h0042, 16'h0000, mae, mdr);
    run("p_ld42", 1'b1, 1'b0, 1'b0, 16'h0042, 16'h0000, 16'h7777, 1'b0, 2 * (W + 1));
    ref_op(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, mae, mdr);
    run("p_ld40b", 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEAD, 1'b0, W + 1);
`endif

    // Random traffic over word indices 0x80..0x8F with random upper address bits (wrap).
    for (int i = 0; i < 16; i++) begin
      a = 16'h0100 | 16'(i << 1);
      mdr = 16'($urandom);
      ref_op(1'b0, 1'b1, 1'b0, a, mdr, mae, mdr);
      run($sformatf("init%0d", i), 1'b0, 1'b1, 1'b0, a, ref_mem[int'(a[8:1])], mdr, 1'b0, WR_STALL);
    end
    for (int i = 0; i < 150; i++) begin
      case ($urandom % 4)
        0: begin rd = 1'b0; wr = 1'b1; end
        1: begin rd = 1'b1; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b0; end
      endcase
      bm = 1'($urandom);
      a = (16'($urandom) & 16'hFE1F) | 16'h0100;
      mdr = 16'($urandom);
      begin
        logic [15:0] wd;
        wd = mdr;
        ref_op(rd, wr, bm, a, wd, mae, mdr);
`ifdef DMEM_POSTED_WRITE_EN
        est = wr ? 0 : -1;
`else
        est = W + 1;
`endif
        run($sformatf("rnd%0d", i), rd, wr, bm, a, wd, mdr, mae, est);
      end
      if ($urandom % 3 == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
